// File: rtl/btn_debouncer_if.sv
// Raw button inputs and debounced button levels for the five-channel debouncer.
// The master side drives the raw buttons and the slave side returns the clean levels.
interface btn_debouncer_if;
    logic i_BTN_U;
    logic i_BTN_L;
    logic i_BTN_M;
    logic i_BTN_R;
    logic i_BTN_D;
    logic o_BTN_U;
    logic o_BTN_L;
    logic o_BTN_M;
    logic o_BTN_R;
    logic o_BTN_D;

    modport master (
        output i_BTN_U, i_BTN_L, i_BTN_M, i_BTN_R, i_BTN_D,
        input  o_BTN_U, o_BTN_L, o_BTN_M, o_BTN_R, o_BTN_D
    );

    modport slave (
        input  i_BTN_U, i_BTN_L, i_BTN_M, i_BTN_R, i_BTN_D,
        output o_BTN_U, o_BTN_L, o_BTN_M, o_BTN_R, o_BTN_D
    );
endinterface

// File: rtl/btn_debouncer.sv
// Five-channel push-button synchroniser and debouncer feeding the edge detector.
// Optional auto-repeat gaps on held buttons are enabled by defining BTN_HOLD_REPEAT_EN.
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 20000000
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    btn_debouncer_if.slave btn
);
    localparam int NCH = 5;
    localparam int CW  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2 || REPEAT_CYCLES > HOLD_CYCLES) begin : g_param_err
        $error("btn_debouncer: illegal DEBOUNCE/HOLD/REPEAT parameter set");
    end

    // Channel order in every vector: U, L, M, R, D from MSB to LSB.
    logic [NCH-1:0] w_raw;
    logic [NCH-1:0] r_sync1;
    logic [NCH-1:0] r_sync2;
    logic [NCH-1:0] r_stable;
    logic [NCH-1:0] r_out;
    logic [CW-1:0]  r_cnt [NCH];

    assign w_raw = {btn.i_BTN_U, btn.i_BTN_L, btn.i_BTN_M, btn.i_BTN_R, btn.i_BTN_D};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_cnt[c] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int c = 0; c < NCH; c++) begin
                // Any sample agreeing with the stable level restarts the count.
                if (r_sync2[c] == r_stable[c]) begin
                    r_cnt[c] <= '0;
                end else if (r_cnt[c] == CNT_LAST) begin
                    r_stable[c] <= r_sync2[c];
                    r_cnt[c]    <= '0;
                end else begin
                    r_cnt[c] <= r_cnt[c] + CW'(1);
                end
            end
        end
    end

`ifdef BTN_HOLD_REPEAT_EN
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - REPEAT_CYCLES);

    logic [HW-1:0]  r_hold [NCH];
    logic [NCH-1:0] r_gap;

    // The count reaching HOLD_CYCLES flags a gap that blanks the output on the next edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gap <= '0;
            r_out <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_hold[c] <= '0;
            end
        end else begin
            r_out <= r_stable & ~r_gap;
            for (int c = 0; c < NCH; c++) begin
                if (!r_stable[c]) begin
                    r_hold[c] <= '0;
                    r_gap[c]  <= 1'b0;
                end else if (r_hold[c] == HOLD_LAST) begin
                    r_hold[c] <= HOLD_RELOAD;
                    r_gap[c]  <= 1'b1;
                end else begin
                    r_hold[c] <= r_hold[c] + HW'(1);
                    r_gap[c]  <= 1'b0;
                end
            end
        end
    end
`else
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= r_stable;
        end
    end
`endif

    assign btn.o_BTN_U = r_out[4];
    assign btn.o_BTN_L = r_out[3];
    assign btn.o_BTN_M = r_out[2];
    assign btn.o_BTN_R = r_out[1];
    assign btn.o_BTN_D = r_out[0];
endmodule
